// File: rtl/ex_gate.sv
// Two-input AND cell with a registered copy, rise pulse, saturating high counter and sticky flag.
// Optional input-combination coverage mask, built only when EX_GATE_COVER_EN is defined.
module ex_gate #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_a,
  input  logic             i_b,
  input  logic             i_clr,
  output logic             o_y,
  output logic             o_y_q,
  output logic             o_rise,
  output logic [CNT_W-1:0] o_hi_cnt,
  output logic             o_sat,
  output logic [3:0]       o_seen,
  output logic             o_all_seen
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic             y_d;
  logic             y_q;
  logic             rise_d;
  logic             rise_q;
  logic [CNT_W-1:0] hi_cnt_d;
  logic [CNT_W-1:0] hi_cnt_q;
  logic             sat_d;
  logic             sat_q;

  assign y_d = i_a & i_b;
  assign o_y = y_d;

  // A clear restarts the count but still counts the sample taken in the same cycle.
  always_comb begin
    hi_cnt_d = hi_cnt_q;
    if (i_clr) begin
      hi_cnt_d = CNT_W'(y_d);
    end else if (y_d && (hi_cnt_q != CntMax)) begin
      hi_cnt_d = hi_cnt_q + 1'b1;
    end
    sat_d  = (i_clr ? 1'b0 : sat_q) | (hi_cnt_d == CntMax);
    rise_d = y_d & ~y_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      y_q      <= 1'b0;
      rise_q   <= 1'b0;
      hi_cnt_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      y_q      <= y_d;
      rise_q   <= rise_d;
      hi_cnt_q <= hi_cnt_d;
      sat_q    <= sat_d;
    end
  end

  assign o_y_q    = y_q;
  assign o_rise   = rise_q;
  assign o_hi_cnt = hi_cnt_q;
  assign o_sat    = sat_q;

`ifdef EX_GATE_COVER_EN
  logic [3:0] seen_d;
  logic [3:0] seen_q;
  logic       all_seen_d;
  logic       all_seen_q;
  logic [3:0] combo_bit;

  // Bit index is {i_a,i_b}; a clear keeps only the combination seen this cycle.
  always_comb begin
    combo_bit  = 4'b0001 << {i_a, i_b};
    seen_d     = i_clr ? combo_bit : (seen_q | combo_bit);
    all_seen_d = (seen_d == 4'b1111);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      seen_q     <= 4'b0000;
      all_seen_q <= 1'b0;
    end else begin
      seen_q     <= seen_d;
      all_seen_q <= all_seen_d;
    end
  end

  assign o_seen     = seen_q;
  assign o_all_seen = all_seen_q;
`else
  assign o_seen     = 4'b0000;
  assign o_all_seen = 1'b0;
`endif

endmodule

// File: tb/tb_ex_gate.sv
// Directed self-checking bench for ex_gate built with CNT_W=2 so saturation is reachable quickly.
// Coverage expectations follow EX_GATE_COVER_EN the same way the design does.
module tb_ex_gate;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             clkEn = 1'b0;
  logic             rst = 1'b1;
  logic             a = 1'b0;
  logic             b = 1'b0;
  logic             clr = 1'b0;
  logic             y;
  logic             yQ;
  logic             rise;
  logic [CNT_W-1:0] hiCnt;
  logic             sat;
  logic [3:0]       seen;
  logic             allSeen;

  int checkCount = 0;
  int passCount = 0;
  int failCount = 0;

  ex_gate #(.CNT_W(CNT_W)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_a(a),
    .i_b(b),
    .i_clr(clr),
    .o_y(y),
    .o_y_q(yQ),
    .o_rise(rise),
    .o_hi_cnt(hiCnt),
    .o_sat(sat),
    .o_seen(seen),
    .o_all_seen(allSeen)
  );

  // Clock only toggles once enabled so the combinational path can be checked with it stopped.
  always #5 clk = clkEn ? ~clk : clk;

  // Drive one set of inputs, let one rising edge take them, then settle 1 ns past the edge.
  task automatic applyStimulus(input logic ta, input logic tb, input logic tclr, input logic trst);
    a = ta;
    b = tb;
    clr = tclr;
    rst = trst;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [3:0] coverExp(input logic [3:0] v);
`ifdef EX_GATE_COVER_EN
    return v;
`else
    return 4'b0000;
`endif
  endfunction

  initial begin
    logic [3:0] ttA;
    logic [3:0] ttB;
    logic [3:0] ttY;
    logic [2:0] seqY;
    logic [2:0] seqCnt [5];
    ttA = 4'b1100;
    ttB = 4'b1010;
    ttY = 4'b1000;

    // Truth table with the clock stopped and reset held.
    for (int i = 0; i < 4; i++) begin
      a = ttA[3-i];
      b = ttB[3-i];
      #1;
      checkOutput($sformatf("truth_%0d%0d", a, b), 32'(y), 32'(ttY[3-i]));
      #9;
    end

    clkEn = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("rst_y_q", 32'(yQ), 32'd0);
    checkOutput("rst_rise", 32'(rise), 32'd0);
    checkOutput("rst_cnt", 32'(hiCnt), 32'd0);
    checkOutput("rst_sat", 32'(sat), 32'd0);
    checkOutput("rst_seen", 32'(seen), 32'd0);
    checkOutput("rst_all_seen", 32'(allSeen), 32'd0);
    checkOutput("rst_y_comb", 32'(y), 32'd1);

    // Sequence y = 0,1,1,0,1: rise pulses on the 2nd and 5th edges, count reaches 3.
    seqY = 3'b0;
    seqCnt[0] = 3'd0; seqCnt[1] = 3'd1; seqCnt[2] = 3'd2; seqCnt[3] = 3'd2; seqCnt[4] = 3'd3;
    begin
      logic [4:0] pat;
      logic [4:0] riseExp;
      pat = 5'b01101;
      riseExp = 5'b01001;
      for (int i = 0; i < 5; i++) begin
        applyStimulus(pat[4-i], pat[4-i], 1'b0, 1'b0);
        checkOutput($sformatf("pipe_y_q_%0d", i), 32'(yQ), 32'(pat[4-i]));
        checkOutput($sformatf("pipe_rise_%0d", i), 32'(rise), 32'(riseExp[4-i]));
        checkOutput($sformatf("pipe_cnt_%0d", i), 32'(hiCnt), 32'(seqCnt[i]));
      end
    end
    checkOutput("pipe_sat", 32'(sat), 32'd1);

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("clr_cnt", 32'(hiCnt), 32'd0);
    checkOutput("clr_sat", 32'(sat), 32'd0);
    checkOutput("clr_rise_unaffected", 32'(rise), 32'd0);

    // Hold (1,1): counter 1,2,3,3,3; sat rises with 3 and sticks; single rise pulse.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("sat_cnt_%0d", i), 32'(hiCnt), (i < 3) ? 32'(i + 1) : 32'd3);
      checkOutput($sformatf("sat_flag_%0d", i), 32'(sat), (i >= 2) ? 32'd1 : 32'd0);
      checkOutput($sformatf("sat_rise_%0d", i), 32'(rise), (i == 0) ? 32'd1 : 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("sat_clr_cnt", 32'(hiCnt), 32'd0);
    checkOutput("sat_clr_flag", 32'(sat), 32'd0);

    // Clear and count in the same cycle, then reset overriding clear.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("cc_pre_cnt", 32'(hiCnt), 32'd2);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("cc_cnt", 32'(hiCnt), 32'd1);
    checkOutput("cc_seen_clr", 32'(seen), 32'(coverExp(4'b1000)));
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("cc_rst_cnt", 32'(hiCnt), 32'd0);
    checkOutput("cc_rst_y_q", 32'(yQ), 32'd0);
    checkOutput("cc_rst_seen", 32'(seen), 32'd0);

    // Coverage accumulation from a clean state.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("cov_00", 32'(seen), 32'(coverExp(4'b0001)));
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("cov_01", 32'(seen), 32'(coverExp(4'b0011)));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("cov_10", 32'(seen), 32'(coverExp(4'b0111)));
    checkOutput("cov_all_pre", 32'(allSeen), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("cov_11", 32'(seen), 32'(coverExp(4'b1111)));
    checkOutput("cov_all", 32'(allSeen), 32'(coverExp(4'b0001)));
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("cov_clr_10", 32'(seen), 32'(coverExp(4'b0100)));
    checkOutput("cov_clr_all", 32'(allSeen), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
